booth_mul_sched: RTL
====================

Name: booth_mul_sched

Overview:
- Shares one external 32x32 signed multiplier instance (e.g. BoothMultiplier) between NREQ requesters.
- Round-robin arbitration; one operation in flight at a time.
- Drives registered operands to the multiplier, waits a fixed MUL_LAT cycles, samples the 64-bit product and returns it tagged with the requester id.
- Sits between the ALU issue logic and the shared multiplier datapath.

Parameters:
- NREQ, 4, number of requesters (2..8).
- ID_W, 2, width of requester id; must satisfy 2**ID_W >= NREQ.
- MUL_LAT, 2, cycles from mul_a/mul_b stable to mul_p valid (1..15).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester grant/accept, one-hot or zero.
- req_a  in  NREQ*32  packed signed multiplicands; requester i uses bits [32i+31:32i].
- req_b  in  NREQ*32  packed signed multipliers, same packing.
- resp_valid  out  1  result valid.
- resp_ready  in  1  result consumer ready.
- resp_id  out  ID_W  index of the requester that owns resp_p.
- resp_p  out  64  signed product.
- mul_a  out  32  registered operand A to the multiplier.
- mul_b  out  32  registered operand B to the multiplier.
- mul_p  in  64  multiplier product.
- busy  out  1  high in any state other than IDLE.

Behaviour:
Reset:
- rst_n low at a clock edge forces state IDLE and clears rr_ptr so requester 0 has top priority.
- All outputs go to 0: req_ready, resp_valid, resp_id, resp_p, mul_a, mul_b, busy.
- Reset mid-operation aborts it; the in-flight product is discarded and no response is produced.

States:
- IDLE, WAIT, RESP.

IDLE:
- Combinational round-robin over req_valid, starting at index (last_grant+1) mod NREQ.
- If any request is valid, assert req_ready for the winner g only, in the same cycle.
- At the clock edge: capture req_a[g] into mul_a, req_b[g] into mul_b, g into resp_id; set last_grant=g; load cnt=MUL_LAT; go to WAIT.
- req_ready is asserted only in IDLE. It is combinational from state and req_valid, with no registered lookahead.

WAIT:
- cnt decrements once per cycle.
- On the cycle with cnt==1: sample mul_p into resp_p and go to RESP.
- mul_a and mul_b stay stable throughout WAIT.

RESP:
- resp_valid=1. resp_id and resp_p stay stable until resp_ready=1 at a clock edge, then go to IDLE.
- No grant in the same cycle as the response handshake.

Timing:
- Latency: request handshake in cycle T gives resp_valid high from cycle T+MUL_LAT+1.
- Maximum throughput: one operation per MUL_LAT+2 cycles when resp_ready is held high.

Output hold and requester rules:
- resp_p and resp_id hold their last values after the handshake until the next capture.
- mul_a and mul_b hold their last operands while idle.
- A requester may drop req_valid without being granted. No stickiness is required; arbitration re-evaluates every IDLE cycle.
- A requester must hold req_a and req_b stable while req_valid is high.

Arithmetic:
- Operands and product are passed unmodified.
- resp_p equals mul_p exactly, full 64-bit two's-complement, with no sign fix-up in this block.

Fairness:
- A requester that stays valid is granted within NREQ grants.

Optional Feature:
- Macro: BOOTH_MUL_SCHED_ZERO_BYPASS_EN.
- Defined: in IDLE, if the winner's a==0 or b==0, the request is accepted normally. resp_id is captured, resp_p is set to 0, and the FSM goes directly IDLE->RESP, skipping WAIT. mul_a and mul_b are not updated. resp_valid rises at T+1.
- Not defined: all requests go through WAIT; zero operands take the full MUL_LAT+1 latency.

Test Plan:
- Reset, then single request: req 1 with a=-3, b=7, MUL_LAT=2, resp_ready=1. Expect req_ready=4'b0010 at T, mul_a=-3 and mul_b=7 from T+1, resp_valid at T+3 with resp_p=-21 and resp_id=1.
- All four requesters valid continuously, resp_ready=1. Expect grant order 0,1,2,3,0, with consecutive grants spaced 4 cycles apart.
- Backpressure: resp_ready=0 for 5 cycles in RESP. Expect resp_valid, resp_p and resp_id stable, no req_ready asserted, busy=1. After resp_ready=1, IDLE on the next cycle.
- Extremes: a=32'h80000000, b=32'h80000000. Expect resp_p=64'h4000000000000000. a=-1, b=1 gives resp_p=64'hFFFFFFFFFFFFFFFF.
- Reset mid-WAIT: rst_n low for 1 cycle at T+1 after a grant. Expect all outputs 0, no resp_valid afterward, next grant to requester 0.
- Zero bypass (macro defined): req 2 with a=0, b=12345. Expect resp_valid at T+1, resp_p=0, resp_id=2, mul_a and mul_b unchanged. Macro undefined: resp_valid at T+3.

Source files
------------

// File: rtl/booth_mul_sched.sv
// rtl/booth_mul_sched.sv - round-robin scheduler sharing one 32x32 signed multiplier among NREQ requesters
// Optional: define BOOTH_MUL_SCHED_ZERO_BYPASS_EN to answer zero-operand requests without waiting on the multiplier.
module booth_mul_sched #(
  parameter int NREQ    = 4,
  parameter int ID_W    = 2,
  parameter int MUL_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*32-1:0]   req_a,
  input  logic [NREQ*32-1:0]   req_b,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [ID_W-1:0]      resp_id,
  output logic [63:0]          resp_p,
  output logic [31:0]          mul_a,
  output logic [31:0]          mul_b,
  input  logic [63:0]          mul_p,
  output logic                 busy
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t          r_state;
  logic [ID_W-1:0] r_rr_ptr;
  logic [3:0]      r_cnt;
  logic            r_resp_valid;
  logic [ID_W-1:0] r_resp_id;
  logic [63:0]     r_resp_p;
  logic [31:0]     r_mul_a;
  logic [31:0]     r_mul_b;
  logic            r_busy;

  logic            w_any;
  logic [ID_W-1:0] w_gnt;
  logic [NREQ-1:0] w_ready;
  logic [31:0]     w_gnt_a;
  logic [31:0]     w_gnt_b;
  logic            w_bypass;
  logic [ID_W-1:0] w_next_ptr;

  function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NREQ) s = s - NREQ;
    return ID_W'(s);
  endfunction

  // Scan starts at r_rr_ptr, the requester after the last one granted.
  always_comb begin
    w_any = 1'b0;
    w_gnt = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_any && req_valid[wrap_idx(r_rr_ptr, k)]) begin
        w_any = 1'b1;
        w_gnt = wrap_idx(r_rr_ptr, k);
      end
    end
  end

  always_comb begin
    w_ready = '0;
    if (rst_n && (r_state == S_IDLE) && w_any) w_ready[w_gnt] = 1'b1;
  end

  assign w_gnt_a    = req_a[32*w_gnt +: 32];
  assign w_gnt_b    = req_b[32*w_gnt +: 32];
  assign w_next_ptr = (w_gnt == ID_W'(NREQ-1)) ? '0 : w_gnt + 1'b1;

`ifdef BOOTH_MUL_SCHED_ZERO_BYPASS_EN
  assign w_bypass = (w_gnt_a == 32'd0) || (w_gnt_b == 32'd0);
`else
  assign w_bypass = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_rr_ptr     <= '0;
      r_cnt        <= '0;
      r_resp_valid <= 1'b0;
      r_resp_id    <= '0;
      r_resp_p     <= '0;
      r_mul_a      <= '0;
      r_mul_b      <= '0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_resp_id <= w_gnt;
            r_rr_ptr  <= w_next_ptr;
            r_busy    <= 1'b1;
            if (w_bypass) begin
              r_resp_p     <= '0;
              r_resp_valid <= 1'b1;
              r_state      <= S_RESP;
            end else begin
              r_mul_a <= w_gnt_a;
              r_mul_b <= w_gnt_b;
              r_cnt   <= 4'(MUL_LAT);
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_resp_p     <= mul_p;
            r_resp_valid <= 1'b1;
            r_state      <= S_RESP;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = w_ready;
  assign resp_valid = r_resp_valid;
  assign resp_id    = r_resp_id;
  assign resp_p     = r_resp_p;
  assign mul_a      = r_mul_a;
  assign mul_b      = r_mul_b;
  assign busy       = r_busy;

endmodule
